// File: rtl/modport_ram.sv
// rtl/modport_ram.sv - dual-port synchronous RAM with per-word valid masking
//
// One write port and one registered read port on a single clock. Words that
// have not been written since the last reset read back as zero.
//
// Optional feature macro: RAM_BYPASS_EN
//   defined   : write-first on a same-address read/write collision
//   undefined : read-first (returns the pre-write contents)
//
// Ports:
//   clock       in   rising-edge clock for all logic
//   reset       in   synchronous active-high reset
//   write       in   write enable
//   wr_address  in   write address (ADDR_WIDTH)
//   data_in     in   write data (DATA_WIDTH)
//   read        in   read enable
//   rd_address  in   read address (ADDR_WIDTH)
//   data_out    out  registered read data (DATA_WIDTH), one cycle latency
module modport_ram #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  write,
    input  logic [ADDR_WIDTH-1:0] wr_address,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  read,
    input  logic [ADDR_WIDTH-1:0] rd_address,
    output logic [DATA_WIDTH-1:0] data_out
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    // The data array carries no reset so it maps onto block RAM; the valid
    // bits alone provide the "reads as zero after reset" behaviour.
    logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];
    logic [DEPTH-1:0]      valid;

    logic                  wr_en;
    logic [DATA_WIDTH-1:0] rd_word;

    // Writes issued during the reset cycle are dropped.
    assign wr_en = write && !reset;

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_address] <= data_in;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            valid <= '0;
        end else if (write) begin
            valid[wr_address] <= 1'b1;
        end
    end

    // Stored contents as seen before this edge's write lands.
    always_comb begin
        rd_word = '0;
        if (valid[rd_address]) begin
            rd_word = mem[rd_address];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            data_out <= '0;
        end else if (read) begin
`ifdef RAM_BYPASS_EN
            // Forward the incoming write data on a same-address collision.
            if (write && (wr_address == rd_address)) begin
                data_out <= data_in;
            end else begin
                data_out <= rd_word;
            end
`else
            data_out <= rd_word;
`endif
        end
    end

endmodule

// File: tb/tb_modport_ram.sv
// tb/tb_modport_ram.sv - directed self-checking bench for modport_ram
module tb_modport_ram;

    logic        clock;
    logic        reset;
    logic        write;
    logic [11:0] wr_address;
    logic [63:0] data_in;
    logic        read;
    logic [11:0] rd_address;
    logic [63:0] data_out;

    int checks = 0;
    int errors = 0;

    modport_ram dut (
        .clock      (clock),
        .reset      (reset),
        .write      (write),
        .wr_address (wr_address),
        .data_in    (data_in),
        .read       (read),
        .rd_address (rd_address),
        .data_out   (data_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to 1 unit after the next rising edge: outputs are settled and
    // new inputs can be driven.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_write(input logic [11:0] a, input logic [63:0] d);
        write = 1'b1; wr_address = a; data_in = d;
        tick();
        write = 1'b0;
    endtask

    task automatic do_read(input string tag, input logic [11:0] a, input logic [63:0] exp);
        read = 1'b1; rd_address = a;
        tick();
        read = 1'b0;
        check(tag, data_out, exp);
    endtask

    logic [63:0] collide_exp;
    logic [63:0] fresh_exp;

    initial begin
        reset = 1'b1; write = 1'b0; read = 1'b0;
        wr_address = '0; rd_address = '0; data_in = '0;
        tick();
        tick();
        check("reset_dout", data_out, 64'h0);
        reset = 1'b0;

        do_read("rd_000_after_reset", 12'h000, 64'h0);
        do_read("rd_7ff_after_reset", 12'h7FF, 64'h0);
        do_read("rd_fff_after_reset", 12'hFFF, 64'h0);

        do_write(12'h00A, 64'h0123_4567_89AB_CDEF);
        do_read("rd_00a", 12'h00A, 64'h0123_4567_89AB_CDEF);
        tick();
        check("hold_00a", data_out, 64'h0123_4567_89AB_CDEF);
        rd_address = 12'h000;
        tick();
        check("hold_addr_change", data_out, 64'h0123_4567_89AB_CDEF);

        // Independent write and read in the same cycle.
        do_write(12'h020, {16{4'h5}});
        write = 1'b1; wr_address = 12'h010; data_in = {16{4'hA}};
        read  = 1'b1; rd_address = 12'h020;
        tick();
        write = 1'b0; read = 1'b0;
        check("indep_rd_020", data_out, {16{4'h5}});
        do_read("rd_010", 12'h010, {16{4'hA}});

        // Same-address collision on a written word.
`ifdef RAM_BYPASS_EN
        collide_exp = {16{4'h2}};
        fresh_exp   = 64'hCAFE_F00D_0000_0040;
`else
        collide_exp = {16{4'h1}};
        fresh_exp   = 64'h0;
`endif
        do_write(12'h030, {16{4'h1}});
        write = 1'b1; wr_address = 12'h030; data_in = {16{4'h2}};
        read  = 1'b1; rd_address = 12'h030;
        tick();
        write = 1'b0; read = 1'b0;
        check("collide_030", data_out, collide_exp);
        do_read("after_collide_030", 12'h030, {16{4'h2}});

        // Collision on a never-written word.
        write = 1'b1; wr_address = 12'h040; data_in = 64'hCAFE_F00D_0000_0040;
        read  = 1'b1; rd_address = 12'h040;
        tick();
        write = 1'b0; read = 1'b0;
        check("collide_040_fresh", data_out, fresh_exp);
        do_read("after_collide_040", 12'h040, 64'hCAFE_F00D_0000_0040);

        // Reset mid-operation, with a write and read in the reset cycle.
        do_write(12'hFFF, 64'hDEAD_BEEF_0000_0001);
        do_read("rd_fff_written", 12'hFFF, 64'hDEAD_BEEF_0000_0001);
        reset = 1'b1;
        write = 1'b1; wr_address = 12'h001; data_in = {64{1'b1}};
        read  = 1'b1; rd_address = 12'hFFF;
        tick();
        reset = 1'b0; write = 1'b0; read = 1'b0;
        check("dout_in_reset", data_out, 64'h0);
        do_read("rd_fff_post_reset", 12'hFFF, 64'h0);
        do_read("rd_001_post_reset", 12'h001, 64'h0);
        do_read("rd_00a_post_reset", 12'h00A, 64'h0);

        // Back-to-back writes then reads, no bubbles.
        write = 1'b1;
        for (int i = 0; i < 16; i++) begin
            wr_address = 12'(i);
            data_in    = 64'(i) * 64'h0101_0101_0101_0101;
            tick();
        end
        write = 1'b0;
        read = 1'b1;
        for (int i = 0; i < 16; i++) begin
            rd_address = 12'(i);
            tick();
            check($sformatf("b2b_rd_%0d", i), data_out, 64'(i) * 64'h0101_0101_0101_0101);
        end
        read = 1'b0;
        tick();
        check("b2b_hold", data_out, 64'h0F0F_0F0F_0F0F_0F0F);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/modport_ram.md
# modport_ram

Dual-port synchronous RAM, 4096 words × 64 bits, with one independent write port and one independent read port on a single clock. It is the storage block driven and monitored through the team's write/read driver and monitor modports. Reads are registered, with one cycle of latency. A per-word valid array makes never-written locations read as zero after reset.

## Interface
- `DATA_WIDTH`, 64, word width.
- `ADDR_WIDTH`, 12, address width; depth = 2^ADDR_WIDTH = 4096.
- `clock`  input  1  rising-edge clock for all logic.
- `reset`  input  1  synchronous, active-high reset.
- `write`  input  1  write enable, sampled on the rising edge of `clock`.
- `wr_address`  input  12  write address.
- `data_in`  input  64  write data.
- `read`  input  1  read enable, sampled on the rising edge of `clock`.
- `rd_address`  input  12  read address.
- `data_out`  output  64  registered read data.

## Operation
- Storage: `mem[4096][64]` plus `valid[4096]`, one bit per word.
- Write: on a rising edge with `write`=1 and `reset`=0:
  - `mem[wr_address]` ← `data_in`.
  - `valid[wr_address]` ← 1.
- Read: on a rising edge with `read`=1 and `reset`=0, `data_out` ← `valid[rd_address] ? mem[rd_address] : 0`.
- `read`=0: `data_out` holds its previous value.
- Reset: on a rising edge with `reset`=1:
  - All `valid` bits clear to 0.
  - `data_out` ← 0.
  - `write` and `read` are ignored in that cycle.
  - `mem` contents are not cleared; they are masked by `valid`.
- Simultaneous write and read to different addresses: the two operations are fully independent.
- Simultaneous write and read to the same address: the result is set by `RAM_BYPASS_EN` (see Configuration).
- No wrap-around or overflow conditions exist. Every 12-bit address is legal. X/Z on an address or enable is not supported.

## Timing
- Read latency: 1 cycle.
  - `data_out` updates on the same rising edge that samples `read`=1.
  - It is stable until the next edge that samples `read`=1, or `reset`=1.
  - Monitors sample `data_out` at the following edge, with a 1-unit input skew.
- Write latency: a word written at edge N is returned by a read sampled at edge N+1 or later.
- Inputs are driven 1 time unit after the clock edge (output skew #1). Setup to the next edge is required; hold is not critical.
- Reset asserted mid-operation:
  - A write in the reset cycle is dropped.
  - Reads after reset deasserts return 0 for all addresses until they are rewritten.
- Reset value of every output: `data_out` = 64'h0.
- There is no handshake, no backpressure and no busy state. The block accepts one read and one write every cycle.

## Configuration
- `RAM_BYPASS_EN` defined (write-first):
  - When `read` and `write` are both 1 and `rd_address` == `wr_address`, `data_out` ← `data_in` of that same edge.
- `RAM_BYPASS_EN` undefined (read-first):
  - The same case returns the pre-write contents: `mem[addr]` if `valid`, else 0.
  - The write still completes.

## Test plan
- Reset, then read addresses 0x000, 0x7FF and 0xFFF → `data_out` = 0 after each read edge.
- Write 0x0123_4567_89AB_CDEF to 0x00A. Next cycle, read 0x00A → `data_out` = 0x0123_4567_89AB_CDEF one cycle after `read`. Deassert `read` → value holds.
- Same cycle, write 0xAAAA…AAAA to 0x010 and read 0x020, which was previously written with 0x5555…5555 → `data_out` = 0x5555…5555, and 0x010 later reads 0xAAAA…AAAA.
- Same-address collision: 0x030 holds 0x1111…1111; write 0x2222…2222 to 0x030 while reading 0x030.
  - With `RAM_BYPASS_EN` → `data_out` = 0x2222…2222.
  - Without it → 0x1111…1111.
  - A subsequent read returns 0x2222…2222 in both builds.
- Write 0xDEAD_BEEF_0000_0001 to 0xFFF, then pulse `reset` for 1 cycle while also writing 0xFFFF…FFFF to 0x001 → `data_out` = 0 during reset. After reset, reads of 0xFFF and 0x001 both return 0.
- Back-to-back: write addresses 0..15 with data = address × 0x0101_0101_0101_0101, then read 0..15 on consecutive cycles → each value appears exactly one cycle after its read, with no bubbles.
